// File: rtl/zout_pkg.sv
// Shared types and default widths for the output-store sequencer.
//   zout_state_e : two-state job FSM encoding (IDLE / RUN)
//   ZOUT_*       : default parameter values for zout_store_ctrl
package zout_pkg;

    typedef enum logic {ZOUT_IDLE, ZOUT_RUN} zout_state_e;

    localparam int unsigned ZOUT_DEPTH_W      = 7;
    localparam int unsigned ZOUT_TAPU_DEPTH_W = 4;
    localparam int unsigned ZOUT_N_TAPU       = 8;

endpackage

// File: rtl/zout_wrap_cnt.sv
// Wrapping counter with load, enable and a wrap flag.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   ld, ld_val : load ld_val (has priority over en)
//   en         : advance; wraps to 0 when at_wrap is high
//   limit      : terminal count when MOD == 0
//   cnt        : current count
//   at_wrap    : count is at its terminal value (limit, or MOD-1 in modulo mode)
// A zero MOD selects a run-time limit; a nonzero MOD makes it a fixed modulo-MOD counter.
module zout_wrap_cnt #(
    parameter int unsigned W   = 4,
    parameter int unsigned MOD = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_wrap
);

    localparam int unsigned   LAST_I   = (MOD > 0) ? MOD - 1 : 0;
    localparam logic [W-1:0]  MOD_LAST = W'(LAST_I);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        at_wrap = (MOD == 0) ? (cnt_q == limit) : (cnt_q == MOD_LAST);
        cnt_d   = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/zout_store_ctrl.sv
// Output-store sequencer: on a start request issues store_depth+1 store beats
// with ready/valid backpressure, stepping the target TAPU every
// store_tapu_depth+1 accepted beats (modulo N_TAPU).
//   clk, rst_n        : clock, asynchronous active-low reset
//   zout_start        : job request, sampled only while idle
//   zout_abort        : synchronous job cancel (blocks a same-cycle start)
//   store_depth       : beats per job minus 1   (latched at start)
//   store_tapu_depth  : beats per TAPU minus 1  (latched at start)
//   tapu_base         : first TAPU index        (latched at start, 0 if out of range)
//   store_ready       : downstream accepts the current beat
//   psu_store_en      : beat valid
//   store_last        : current beat is the final beat of the job
//   tapu_store_idx    : TAPU targeted by current beat
//   zout_busy         : job in progress
//   zout_done         : one-cycle pulse the cycle after the final beat
module zout_store_ctrl import zout_pkg::*; #(
    parameter  int unsigned DEPTH_W      = ZOUT_DEPTH_W,
    parameter  int unsigned TAPU_DEPTH_W = ZOUT_TAPU_DEPTH_W,
    parameter  int unsigned N_TAPU       = ZOUT_N_TAPU,
    localparam int unsigned IDX_W        = $clog2(N_TAPU)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    zout_start,
    input  logic                    zout_abort,
    input  logic [DEPTH_W-1:0]      store_depth,
    input  logic [TAPU_DEPTH_W-1:0] store_tapu_depth,
    input  logic [IDX_W-1:0]        tapu_base,
    input  logic                    store_ready,
    output logic                    psu_store_en,
    output logic                    store_last,
    output logic [IDX_W-1:0]        tapu_store_idx,
    output logic                    zout_busy,
    output logic                    zout_done
);

    zout_state_e state_q, state_d;

    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic [TAPU_DEPTH_W-1:0] tdepth_q, tdepth_d;
    logic                    done_q, done_d;

    logic                    run;
    logic                    beat;
    logic                    start_acc;
    logic                    last_beat;
    logic                    cnt_clr;
    logic                    cnt_en;
    logic                    idx_en;
    logic [IDX_W-1:0]        idx_ld_val;

    logic [DEPTH_W-1:0]      cnt_beat;
    logic                    beat_wrap;
    logic [TAPU_DEPTH_W-1:0] cnt_tapu;
    logic                    tapu_wrap;
    logic [IDX_W-1:0]        idx;
    logic                    idx_wrap;

    // Handshake and control decode. Abort overrides a simultaneous beat for
    // counter purposes: the counters simply clear instead of advancing.
    always_comb begin
        run        = (state_q == ZOUT_RUN);
        beat       = run & store_ready;
        start_acc  = ~run & zout_start & ~zout_abort;
        last_beat  = beat & beat_wrap & ~zout_abort;
        cnt_clr    = start_acc | (run & zout_abort) | last_beat;
        cnt_en     = beat & ~zout_abort;
        idx_en     = cnt_en & tapu_wrap;
        idx_ld_val = (32'(tapu_base) < N_TAPU) ? tapu_base : '0;
        depth_d    = start_acc ? store_depth : depth_q;
        tdepth_d   = start_acc ? store_tapu_depth : tdepth_q;
        done_d     = last_beat;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ZOUT_IDLE: if (zout_start && !zout_abort)  state_d = ZOUT_RUN;
            ZOUT_RUN:  if (zout_abort || last_beat)    state_d = ZOUT_IDLE;
            default:                                   state_d = ZOUT_IDLE;
        endcase
    end

    // State and job registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ZOUT_IDLE;
            depth_q  <= '0;
            tdepth_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            tdepth_q <= tdepth_d;
            done_q   <= done_d;
        end
    end

    zout_wrap_cnt #(.W(DEPTH_W), .MOD(0)) u_cnt_beat (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (cnt_clr),
        .ld_val  ('0),
        .en      (cnt_en),
        .limit   (depth_q),
        .cnt     (cnt_beat),
        .at_wrap (beat_wrap)
    );

    zout_wrap_cnt #(.W(TAPU_DEPTH_W), .MOD(0)) u_cnt_tapu (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (cnt_clr),
        .ld_val  ('0),
        .en      (cnt_en),
        .limit   (tdepth_q),
        .cnt     (cnt_tapu),
        .at_wrap (tapu_wrap)
    );

    // TAPU index only reloads at start; its value after a job is irrelevant.
    zout_wrap_cnt #(.W(IDX_W), .MOD(N_TAPU)) u_tapu_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (start_acc),
        .ld_val  (idx_ld_val),
        .en      (idx_en),
        .limit   ('0),
        .cnt     (idx),
        .at_wrap (idx_wrap)
    );

    // Output logic: valid is purely a function of state, never of store_ready.
    always_comb begin
        psu_store_en   = run;
        zout_busy      = run;
        store_last     = run & beat_wrap;
        tapu_store_idx = idx;
        zout_done      = done_q;
    end

    logic unused_ok;
    assign unused_ok = ^{cnt_beat, cnt_tapu, idx_wrap};

endmodule

// File: tb/tb_zout_store_ctrl.sv
module tb_zout_store_ctrl;

    localparam int N     = 6;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             zout_start;
    logic             zout_abort;
    logic [6:0]       store_depth;
    logic [3:0]       store_tapu_depth;
    logic [IDX_W-1:0] tapu_base;
    logic             store_ready;
    logic             psu_store_en;
    logic             store_last;
    logic [IDX_W-1:0] tapu_store_idx;
    logic             zout_busy;
    logic             zout_done;

    zout_store_ctrl #(
        .DEPTH_W      (7),
        .TAPU_DEPTH_W (4),
        .N_TAPU       (N)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .zout_start       (zout_start),
        .zout_abort       (zout_abort),
        .store_depth      (store_depth),
        .store_tapu_depth (store_tapu_depth),
        .tapu_base        (tapu_base),
        .store_ready      (store_ready),
        .psu_store_en     (psu_store_en),
        .store_last       (store_last),
        .tapu_store_idx   (tapu_store_idx),
        .zout_busy        (zout_busy),
        .zout_done        (zout_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is an ordered list of expected beats, built from
    // the configuration at acceptance; each accepted beat pops one entry.
    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_run  = 1'b0;
    bit    m_done = 1'b0;

    always @(negedge clk) begin : monitor
        beat_t e;
        int    be;
        if (!rst_n) begin
            exp_q.delete();
            m_run  = 1'b0;
            m_done = 1'b0;
            chk("rst_en",   psu_store_en,   0);
            chk("rst_last", store_last,     0);
            chk("rst_idx",  tapu_store_idx, 0);
            chk("rst_busy", zout_busy,      0);
            chk("rst_done", zout_done,      0);
        end else begin
            chk("busy",  zout_busy,    m_run);
            chk("valid", psu_store_en, m_run);
            chk("done",  zout_done,    m_done);
            m_done = 1'b0;
            if (m_run) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                    m_run = 1'b0;
                end else begin
                    chk("idx",  tapu_store_idx, exp_q[0].idx);
                    chk("last", store_last,     exp_q[0].last);
                    if (zout_abort) begin
                        exp_q.delete();
                        m_run = 1'b0;
                    end else if (store_ready) begin
                        e = exp_q.pop_front();
                        if (e.last) begin
                            m_run  = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end
            end else if (zout_start && !zout_abort) begin
                be = (int'(tapu_base) < N) ? int'(tapu_base) : 0;
                for (int k = 0; k <= int'(store_depth); k++) begin
                    e.idx  = (be + k / (int'(store_tapu_depth) + 1)) % N;
                    e.last = (k == int'(store_depth));
                    exp_q.push_back(e);
                end
                m_run = 1'b1;
            end
        end
    end

    function automatic logic ready_pat(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the done
    // cycle. With hold set, zout_start stays high for a back-to-back job.
    task automatic do_job(input int d, input int td, input int b, input int mode, input bit hold);
        bit got = 1'b0;
        store_depth      = 7'(d);
        store_tapu_depth = 4'(td);
        tapu_base        = IDX_W'(b);
        zout_start       = 1'b1;
        store_ready      = ready_pat(mode, 0);
        @(posedge clk); #1;
        if (!hold) zout_start = 1'b0;
        store_depth      = 7'($urandom);
        store_tapu_depth = 4'($urandom);
        tapu_base        = IDX_W'($urandom);
        for (int cyc = 1; cyc < 2000 && !got; cyc++) begin
            store_ready = ready_pat(mode, cyc);
            @(posedge clk); #1;
            if (zout_done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n            = 1'b0;
        zout_start       = 1'b0;
        zout_abort       = 1'b0;
        store_depth      = '0;
        store_tapu_depth = '0;
        tapu_base        = '0;
        store_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic run and backpressure
        do_job(7, 1, 0, 0, 1'b0);
        @(posedge clk); #1;
        do_job(7, 1, 0, 1, 1'b0);
        @(posedge clk); #1;

        // Wrap with non-power-of-two TAPU count, out-of-range base
        do_job(9, 0, 4, 0, 1'b0);
        do_job(5, 0, 7, 2, 1'b0);

        // Edge lengths
        do_job(0, 0, 3, 0, 1'b0);
        do_job(0, 2, 1, 1, 1'b0);
        do_job(127, 15, 0, 0, 1'b0);
        do_job(127, 0, 5, 2, 1'b0);

        // Abort in idle blocks start
        zout_start = 1'b1; zout_abort = 1'b1; store_depth = 7'd3;
        @(posedge clk); #1;
        zout_start = 1'b0; zout_abort = 1'b0;
        @(posedge clk); #1;

        // Abort on beat 3, restart in the following cycle
        store_depth = 7'd7; store_tapu_depth = 4'd1; tapu_base = IDX_W'(2);
        zout_start = 1'b1; store_ready = 1'b1;
        @(posedge clk); #1;
        zout_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 zout_abort = 1'b1;
        @(posedge clk); #1;
        zout_abort = 1'b0;
        do_job(3, 0, 5, 0, 1'b0);

        // Back-to-back: start held across the done cycle
        do_job(4, 1, 1, 0, 1'b1);
        do_job(2, 0, 3, 1, 1'b0);
        @(posedge clk); #1;

        // Random jobs
        for (int j = 0; j < 12; j++) begin
            do_job($urandom_range(0, 20), $urandom_range(0, 3),
                   $urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        zout_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset mid-job, between clock edges
        store_depth = 7'd50; store_tapu_depth = 4'd0; tapu_base = IDX_W'(3);
        zout_start = 1'b1; store_ready = 1'b1;
        @(posedge clk); #1;
        zout_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en",   psu_store_en,   0);
        chk("async_last", store_last,     0);
        chk("async_idx",  tapu_store_idx, 0);
        chk("async_busy", zout_busy,      0);
        chk("async_done", zout_done,      0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_job(2, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
